// File: rtl/wb_write_queue_if.sv
// Write-back result handshake between the write-back mux (master) and the
// write queue (slave). A transfer completes on a rising clock edge where
// wb_valid_i and wb_ready_o are both high. The master holds wb_addr_i and
// wb_data_i stable while wb_valid_i is high. wb_ready_o does not depend on
// wb_valid_i.
interface wb_write_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wb_valid_i;
  logic              wb_ready_o;
  logic [ADDR_W-1:0] wb_addr_i;
  logic [DATA_W-1:0] wb_data_i;

  modport master (
    output wb_valid_i,
    output wb_addr_i,
    output wb_data_i,
    input  wb_ready_o
  );

  modport slave (
    input  wb_valid_i,
    input  wb_addr_i,
    input  wb_data_i,
    output wb_ready_o
  );
endinterface

// File: rtl/wb_write_queue.sv
// Write-back queue in front of the register file write port. Completed
// results are buffered in a small FIFO and drained one per cycle into a
// registered output stage (RDaddr_o/RDdata_o/RegWrite_o). Pending values,
// including the one currently in the output stage, are forwarded to the
// rs/rt decode lookups so reads stay coherent with uncommitted writes.
module wb_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  wb_write_queue_if.slave        wb,
  input  logic                   drain_en_i,
  output logic [ADDR_W-1:0]      RDaddr_o,
  output logic [DATA_W-1:0]      RDdata_o,
  output logic                   RegWrite_o,
  input  logic [ADDR_W-1:0]      rs_addr_i,
  input  logic [ADDR_W-1:0]      rt_addr_i,
  output logic                   rs_hit_o,
  output logic [DATA_W-1:0]      rs_data_o,
  output logic                   rt_hit_o,
  output logic [DATA_W-1:0]      rt_data_o,
  output logic [$clog2(DEPTH):0] pending_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic handshake;
  logic enq;
  logic deq;

  // No pass-through: a full queue refuses even if it drains this cycle.
  assign wb.wb_ready_o = (count != CW'(DEPTH));
  assign handshake     = wb.wb_valid_i && wb.wb_ready_o;
  // Writes to $0 complete the handshake but are dropped here.
  assign enq           = handshake && (wb.wb_addr_i != '0);
  assign deq           = (count != '0) && drain_en_i;

  assign pending_o = count;
  assign empty_o   = (count == '0) && !RegWrite_o;

  // Entry storage; contents are only meaningful inside the count window.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      addr_mem[wr_ptr] <= wb.wb_addr_i;
      data_mem[wr_ptr] <= wb.wb_data_i;
    end
  end

  // Pointers, occupancy and the registered write-port stage.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      RDaddr_o   <= '0;
      RDdata_o   <= '0;
      RegWrite_o <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (deq) begin
        RDaddr_o <= addr_mem[rd_ptr];
        RDdata_o <= data_mem[rd_ptr];
        rd_ptr   <= rd_ptr + PW'(1);
      end
      RegWrite_o <= deq;
      count      <= count + CW'(enq) - CW'(deq);
    end
  end

  // Forwarding: output stage first, then FIFO oldest to youngest, so the
  // youngest matching entry is the last one to overwrite the result.
  always_comb begin
    rs_hit_o  = 1'b0;
    rs_data_o = '0;
    rt_hit_o  = 1'b0;
    rt_data_o = '0;
    if (RegWrite_o) begin
      if ((rs_addr_i != '0) && (RDaddr_o == rs_addr_i)) begin
        rs_hit_o  = 1'b1;
        rs_data_o = RDdata_o;
      end
      if ((rt_addr_i != '0) && (RDaddr_o == rt_addr_i)) begin
        rt_hit_o  = 1'b1;
        rt_data_o = RDdata_o;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        if ((rs_addr_i != '0) && (addr_mem[rd_ptr + PW'(i)] == rs_addr_i)) begin
          rs_hit_o  = 1'b1;
          rs_data_o = data_mem[rd_ptr + PW'(i)];
        end
        if ((rt_addr_i != '0) && (addr_mem[rd_ptr + PW'(i)] == rt_addr_i)) begin
          rt_hit_o  = 1'b1;
          rt_data_o = data_mem[rd_ptr + PW'(i)];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: reset, latency, full, forwarding, $0,
// pointer wrap and mid-burst reset. A negedge monitor checks every register
// file write against the queue of accepted (addr,data) pairs.
module tb_wb_write_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk_i;
  logic              rst_i;
  logic              drain_en_i;
  logic [ADDR_W-1:0] RDaddr_o;
  logic [DATA_W-1:0] RDdata_o;
  logic              RegWrite_o;
  logic [ADDR_W-1:0] rs_addr_i;
  logic [ADDR_W-1:0] rt_addr_i;
  logic              rs_hit_o;
  logic [DATA_W-1:0] rs_data_o;
  logic              rt_hit_o;
  logic [DATA_W-1:0] rt_data_o;
  logic [$clog2(DEPTH):0] pending_o;
  logic              empty_o;

  wb_write_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb_bus ();

  wb_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wb         (wb_bus.slave),
    .drain_en_i (drain_en_i),
    .RDaddr_o   (RDaddr_o),
    .RDdata_o   (RDdata_o),
    .RegWrite_o (RegWrite_o),
    .rs_addr_i  (rs_addr_i),
    .rt_addr_i  (rt_addr_i),
    .rs_hit_o   (rs_hit_o),
    .rs_data_o  (rs_data_o),
    .rt_hit_o   (rt_hit_o),
    .rt_data_o  (rt_data_o),
    .pending_o  (pending_o),
    .empty_o    (empty_o)
  );

  // Clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int vectors;
  int miscompares;
  int write_count;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write-port pulse must match the oldest accepted entry.
  always @(negedge clk_i) begin
    if (rst_i && RegWrite_o) begin
      write_count++;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_write", 32'(RegWrite_o), 32'd0);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        chk("sb_addr", 32'(RDaddr_o), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
        chk("sb_data", RDdata_o, e[DATA_W-1:0]);
      end
    end
  end

  // Drivers
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic enq(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_bus.wb_valid_i = 1'b1;
    wb_bus.wb_addr_i  = a;
    wb_bus.wb_data_i  = d;
    chk("enq_ready", 32'(wb_bus.wb_ready_o), 32'd1);
    if (a != '0) exp_q.push_back({a, d});
    step();
    wb_bus.wb_valid_i = 1'b0;
  endtask

  initial begin
    int next_id;
    int budget;
    int wc0;
    vectors     = 0;
    miscompares = 0;
    write_count = 0;
    rst_i       = 1'b0;
    drain_en_i  = 1'b0;
    rs_addr_i   = '0;
    rt_addr_i   = '0;
    wb_bus.wb_valid_i = 1'b0;
    wb_bus.wb_addr_i  = '0;
    wb_bus.wb_data_i  = '0;

    // Reset state
    #12;
    chk("rst_regwrite", 32'(RegWrite_o), 32'd0);
    chk("rst_rdaddr", 32'(RDaddr_o), 32'd0);
    chk("rst_rddata", RDdata_o, 32'd0);
    chk("rst_pending", 32'(pending_o), 32'd0);
    chk("rst_ready", 32'(wb_bus.wb_ready_o), 32'd1);
    chk("rst_empty", 32'(empty_o), 32'd1);
    rst_i = 1'b1;
    step();

    // T2 latency
    drain_en_i = 1'b1;
    enq(5'd8, 32'h1234);
    chk("t2_k_regwrite", 32'(RegWrite_o), 32'd0);
    chk("t2_k_pending", 32'(pending_o), 32'd1);
    step();
    chk("t2_k1_regwrite", 32'(RegWrite_o), 32'd1);
    chk("t2_k1_rdaddr", 32'(RDaddr_o), 32'd8);
    chk("t2_k1_rddata", RDdata_o, 32'h1234);
    chk("t2_k1_empty", 32'(empty_o), 32'd0);
    step();
    chk("t2_k2_regwrite", 32'(RegWrite_o), 32'd0);
    chk("t2_k2_empty", 32'(empty_o), 32'd1);

    // T3 full
    drain_en_i = 1'b0;
    for (int i = 0; i < 4; i++) enq(5'(11 + i), 32'h100 + 32'(i));
    wb_bus.wb_valid_i = 1'b1;
    wb_bus.wb_addr_i  = 5'd15;
    wb_bus.wb_data_i  = 32'h104;
    chk("t3_full_ready", 32'(wb_bus.wb_ready_o), 32'd0);
    chk("t3_full_pending", 32'(pending_o), 32'd4);
    step();
    chk("t3_refused_pending", 32'(pending_o), 32'd4);
    wb_bus.wb_valid_i = 1'b0;
    drain_en_i = 1'b1;
    step();
    chk("t3_d1_regwrite", 32'(RegWrite_o), 32'd1);
    chk("t3_d1_rdaddr", 32'(RDaddr_o), 32'd11);
    chk("t3_d1_ready", 32'(wb_bus.wb_ready_o), 32'd1);
    chk("t3_d1_pending", 32'(pending_o), 32'd3);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("t3_dn_regwrite", 32'(RegWrite_o), 32'd1);
      chk("t3_dn_rdaddr", 32'(RDaddr_o), 32'(11 + i));
    end
    step();
    chk("t3_done_regwrite", 32'(RegWrite_o), 32'd0);
    chk("t3_done_pending", 32'(pending_o), 32'd0);

    // T4 forwarding
    drain_en_i = 1'b0;
    enq(5'd3, 32'hA);
    enq(5'd3, 32'hB);
    rs_addr_i = 5'd3;
    rt_addr_i = 5'd4;
    #1;
    chk("t4_rs_hit", 32'(rs_hit_o), 32'd1);
    chk("t4_rs_data", rs_data_o, 32'hB);
    chk("t4_rt_hit", 32'(rt_hit_o), 32'd0);
    chk("t4_rt_data", rt_data_o, 32'h0);
    drain_en_i = 1'b1;
    step();
    drain_en_i = 1'b0;
    chk("t4_out_data", RDdata_o, 32'hA);
    chk("t4_rs_young", rs_data_o, 32'hB);
    chk("t4_pending", 32'(pending_o), 32'd1);
    drain_en_i = 1'b1;
    step();
    drain_en_i = 1'b0;
    chk("t4_stage_hit", 32'(rs_hit_o), 32'd1);
    chk("t4_stage_data", rs_data_o, 32'hB);
    chk("t4_stage_pending", 32'(pending_o), 32'd0);
    step();
    chk("t4_gone_hit", 32'(rs_hit_o), 32'd0);
    chk("t4_gone_data", rs_data_o, 32'h0);

    // T5 $0
    drain_en_i = 1'b1;
    rs_addr_i  = 5'd0;
    enq(5'd0, 32'hFFFF);
    chk("t5_pending", 32'(pending_o), 32'd0);
    chk("t5_rs0_hit", 32'(rs_hit_o), 32'd0);
    step();
    chk("t5_no_write", 32'(RegWrite_o), 32'd0);
    chk("t5_empty", 32'(empty_o), 32'd1);

    // T6 wrap: r1..r10, data=addr, drain toggling
    wc0     = write_count;
    next_id = 1;
    budget  = 0;
    while ((next_id <= 10 || !empty_o) && budget < 200) begin
      drain_en_i = (next_id <= 10) ? budget[0] : 1'b1;
      if (next_id <= 10) begin
        wb_bus.wb_valid_i = 1'b1;
        wb_bus.wb_addr_i  = 5'(next_id);
        wb_bus.wb_data_i  = 32'(next_id);
        if (wb_bus.wb_ready_o) begin
          exp_q.push_back({5'(next_id), 32'(next_id)});
          next_id++;
        end
      end else begin
        wb_bus.wb_valid_i = 1'b0;
      end
      step();
      budget++;
    end
    wb_bus.wb_valid_i = 1'b0;
    chk("t6_budget", 32'(budget < 200), 32'd1);
    #5;
    chk("t6_writes", 32'(write_count - wc0), 32'd10);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);
    step();

    // T1 reset mid-burst
    drain_en_i = 1'b0;
    enq(5'd20, 32'h20);
    enq(5'd21, 32'h21);
    enq(5'd22, 32'h22);
    chk("t1_pending3", 32'(pending_o), 32'd3);
    drain_en_i = 1'b1;
    step();
    chk("t1_burst_regwrite", 32'(RegWrite_o), 32'd1);
    #2;
    rst_i = 1'b0;
    exp_q.delete();
    #1;
    chk("t1_async_regwrite", 32'(RegWrite_o), 32'd0);
    chk("t1_async_pending", 32'(pending_o), 32'd0);
    chk("t1_async_empty", 32'(empty_o), 32'd1);
    step();
    step();
    rst_i = 1'b1;
    wc0 = write_count;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_post_regwrite", 32'(RegWrite_o), 32'd0);
      chk("t1_post_pending", 32'(pending_o), 32'd0);
    end
    #5;
    chk("t1_post_writes", 32'(write_count - wc0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
